// File: rtl/multi_debouncer.sv
// Multi-channel push-button debouncer.
// Each channel has a 2-flop synchronizer, a 4-state filter FSM and a window counter.
// EARLY=0 accepts a level only after it has been stable for the whole window.
// EARLY=1 follows the first edge at once and then ignores the input for the window.
module multi_debouncer #(
    parameter int CHANNELS     = 4,
    parameter int DELAY_CYCLES = 1_000_000,
    parameter bit EARLY        = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] deb,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    localparam int CW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CW-1:0] DONE_VAL = CW'(DELAY_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    logic [CHANNELS-1:0] sync1_q, sync2_q;
    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic [CW-1:0]       cnt_q   [CHANNELS];
    logic [CW-1:0]       cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] deb_q, deb_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;

    // Two-flop synchronizer bringing the asynchronous inputs into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel next state, window counter and registered output values.
    always_comb begin
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = '0;
            deb_d[ch]   = 1'b0;
            rise_d[ch]  = 1'b0;
            fall_d[ch]  = 1'b0;

            case (state_q[ch])
                IDLE: begin
                    if (sync2_q[ch]) state_d[ch] = WAIT1;
                end
                WAIT1: begin
                    if (!EARLY && !sync2_q[ch])         state_d[ch] = IDLE;
                    else if (cnt_q[ch] == DONE_VAL)     state_d[ch] = ONE;
                end
                ONE: begin
                    if (!sync2_q[ch]) state_d[ch] = WAIT0;
                end
                WAIT0: begin
                    if (!EARLY && sync2_q[ch])          state_d[ch] = ONE;
                    else if (cnt_q[ch] == DONE_VAL)     state_d[ch] = IDLE;
                end
                default: state_d[ch] = IDLE;
            endcase

            // Counter runs only while staying in the same WAIT state; any entry restarts it at 0.
            if ((state_q[ch] == WAIT1 && state_d[ch] == WAIT1) ||
                (state_q[ch] == WAIT0 && state_d[ch] == WAIT0)) begin
                cnt_d[ch] = cnt_q[ch] + 1'b1;
            end

            // Debounced level is decoded from the next state so it is registered alongside it.
            if (EARLY) deb_d[ch] = (state_d[ch] == WAIT1) || (state_d[ch] == ONE);
            else       deb_d[ch] = (state_d[ch] == ONE)   || (state_d[ch] == WAIT0);

            rise_d[ch] = deb_d[ch] & ~deb_q[ch];
            fall_d[ch] = ~deb_d[ch] & deb_q[ch];
        end
    end

    // State, counter and output registers; reset clears everything without a fall pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                state_q[ch] <= IDLE;
                cnt_q[ch]   <= '0;
            end
            deb_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign deb  = deb_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: five configurations driven by the same inputs,
// each checked every cycle against a run-length / lockout model.
module tb_multi_debouncer;

    localparam int NCFG = 5;
    localparam int DLY   [NCFG] = '{8, 8, 4, 4, 1};
    localparam bit EARLYP[NCFG] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din;
    logic [3:0] deb_w  [NCFG];
    logic [3:0] rise_w [NCFG];
    logic [3:0] fall_w [NCFG];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_debouncer #(.CHANNELS(4), .DELAY_CYCLES(8), .EARLY(1'b0)) u_del8 (
        .clk(clk), .reset(reset), .din(din), .deb(deb_w[0]), .rise(rise_w[0]), .fall(fall_w[0]));
    multi_debouncer #(.CHANNELS(4), .DELAY_CYCLES(8), .EARLY(1'b1)) u_early8 (
        .clk(clk), .reset(reset), .din(din), .deb(deb_w[1]), .rise(rise_w[1]), .fall(fall_w[1]));
    multi_debouncer #(.CHANNELS(4), .DELAY_CYCLES(4), .EARLY(1'b0)) u_del4 (
        .clk(clk), .reset(reset), .din(din), .deb(deb_w[2]), .rise(rise_w[2]), .fall(fall_w[2]));
    multi_debouncer #(.CHANNELS(4), .DELAY_CYCLES(4), .EARLY(1'b1)) u_early4 (
        .clk(clk), .reset(reset), .din(din), .deb(deb_w[3]), .rise(rise_w[3]), .fall(fall_w[3]));
    multi_debouncer #(.CHANNELS(4), .DELAY_CYCLES(1), .EARLY(1'b0)) u_del1 (
        .clk(clk), .reset(reset), .din(din), .deb(deb_w[4]), .rise(rise_w[4]), .fall(fall_w[4]));

    // Reference model.
    // s seen at an edge is din sampled two edges earlier.
    // Delayed: deb flips once s has differed from deb on D+1 consecutive edges.
    // Early:   deb flips on the first differing edge, then D edges are ignored.
    logic [3:0] d1 = '0, d2 = '0;
    logic [3:0] m_deb  [NCFG];
    logic [3:0] m_rise [NCFG];
    logic [3:0] m_fall [NCFG];
    int         run    [NCFG][4];
    bit         started = 1'b0;

    always @(posedge clk) begin
        for (int c = 0; c < NCFG; c++) begin
            for (int ch = 0; ch < 4; ch++) begin
                logic prev;
                prev = m_deb[c][ch];
                m_rise[c][ch] = 1'b0;
                m_fall[c][ch] = 1'b0;
                if (reset) begin
                    m_deb[c][ch] = 1'b0;
                    run[c][ch]   = 0;
                end else begin
                    if (!EARLYP[c]) begin
                        if (d2[ch] != m_deb[c][ch]) begin
                            run[c][ch]++;
                            if (run[c][ch] == DLY[c] + 1) begin
                                m_deb[c][ch] = ~m_deb[c][ch];
                                run[c][ch]   = 0;
                            end
                        end else begin
                            run[c][ch] = 0;
                        end
                    end else begin
                        if (run[c][ch] > 0) begin
                            run[c][ch]--;
                        end else if (d2[ch] != m_deb[c][ch]) begin
                            m_deb[c][ch] = ~m_deb[c][ch];
                            run[c][ch]   = DLY[c];
                        end
                    end
                    m_rise[c][ch] = m_deb[c][ch] & ~prev;
                    m_fall[c][ch] = ~m_deb[c][ch] & prev;
                end
            end
        end
        if (reset) begin
            d1 = '0;
            d2 = '0;
        end else begin
            d2 = d1;
            d1 = din;
        end
        started = 1'b1;
    end

    // Compare every configuration against the model on every cycle.
    always @(negedge clk) begin
        if (started) begin
            for (int c = 0; c < NCFG; c++) begin
                checks += 3;
                if (deb_w[c] !== m_deb[c]) begin
                    errors++;
                    $display("FAIL deb cfg%0d t=%0t: got %b expected %b", c, $time, deb_w[c], m_deb[c]);
                end
                if (rise_w[c] !== m_rise[c]) begin
                    errors++;
                    $display("FAIL rise cfg%0d t=%0t: got %b expected %b", c, $time, rise_w[c], m_rise[c]);
                end
                if (fall_w[c] !== m_fall[c]) begin
                    errors++;
                    $display("FAIL fall cfg%0d t=%0t: got %b expected %b", c, $time, fall_w[c], m_fall[c]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int c = 0; c < NCFG; c++) begin
            m_deb[c]  = '0;
            m_rise[c] = '0;
            m_fall[c] = '0;
            for (int ch = 0; ch < 4; ch++) run[c][ch] = 0;
        end
        reset = 1'b1;
        din   = '0;

        // Reset state, then a stable rise on ch0 (E0 = edge after this negedge).
        cyc(3);
        for (int c = 0; c < NCFG; c++) begin
            chk($sformatf("reset deb cfg%0d", c), deb_w[c], 4'b0000);
            chk($sformatf("reset rise cfg%0d", c), rise_w[c], 4'b0000);
        end
        reset = 1'b0;
        cyc(2);
        din = 4'b0001;
        cyc(2);  chk("early8 deb before E0+2", deb_w[1], 4'b0000);
        cyc(1);  chk("early8 deb at E0+2", deb_w[1], 4'b0001);
                 chk("early8 rise at E0+2", rise_w[1], 4'b0001);
        cyc(1);  chk("early8 rise one cycle", rise_w[1], 4'b0000);
        cyc(2);  chk("del4 deb before E0+6", deb_w[2], 4'b0000);
        cyc(1);  chk("del4 deb at E0+6", deb_w[2], 4'b0001);
        cyc(3);  chk("del8 deb before E0+10", deb_w[0], 4'b0000);
        cyc(1);  chk("del8 deb at E0+10", deb_w[0], 4'b0001);
                 chk("del8 rise at E0+10", rise_w[0], 4'b0001);
        cyc(1);  chk("del8 rise one cycle", rise_w[0], 4'b0000);

        // Bounce on ch1: high 5, low 2, then high stable.
        din = 4'b0011; cyc(5);
        din = 4'b0001; cyc(2);
        chk("del8 ignores burst", deb_w[0], 4'b0001);
        din = 4'b0011;
        cyc(10); chk("del8 bounce before E0+10", deb_w[0], 4'b0001);
        cyc(1);  chk("del8 bounce deb", deb_w[0], 4'b0011);
                 chk("del8 bounce rise", rise_w[0], 4'b0010);

        // Early mode ch2: high, brief low inside the lockout, high again.
        din = 4'b0111; cyc(2);
        din = 4'b0011; cyc(3);
        din = 4'b0111; cyc(1);
        chk("early8 ch2 held", deb_w[1], 4'b0111);
        chk("early8 ch2 no fall", fall_w[1], 4'b0000);
        cyc(20);
        for (int c = 0; c < NCFG; c++) chk($sformatf("settled high cfg%0d", c), deb_w[c], 4'b0111);

        // Release with bounce: low 2, high 1, low stable.
        din = 4'b0000; cyc(2);
        din = 4'b0111; cyc(1);
        din = 4'b0000;
        chk("early4 fall at first low+2", fall_w[3], 4'b0111);
        cyc(6);  chk("del4 deb held", deb_w[2], 4'b0111);
        cyc(1);  chk("del4 deb released", deb_w[2], 4'b0000);
                 chk("del4 fall", fall_w[2], 4'b0111);
        cyc(20);

        // Simultaneous channels, then release ch3 alone.
        din = 4'b1111;
        cyc(11); chk("del8 all rise deb", deb_w[0], 4'b1111);
                 chk("del8 all rise", rise_w[0], 4'b1111);
        din = 4'b0111;
        cyc(11); chk("del8 ch3 released", deb_w[0], 4'b0111);
                 chk("del8 ch3 fall only", fall_w[0], 4'b1000);

        // Reset while ch0 is in WAIT1 and ch1 in ONE.
        din = 4'b0010; cyc(20);
        din = 4'b0011; cyc(4);
        reset = 1'b1;  cyc(1);
        for (int c = 0; c < NCFG; c++) begin
            chk($sformatf("midreset deb cfg%0d", c), deb_w[c], 4'b0000);
            chk($sformatf("midreset fall cfg%0d", c), fall_w[c], 4'b0000);
        end
        reset = 1'b0;
        cyc(10); chk("del8 after reset early", deb_w[0], 4'b0000);
        cyc(1);  chk("del8 after reset full window", deb_w[0], 4'b0011);
                 chk("del8 after reset rise", rise_w[0], 4'b0011);

        // Random bouncing with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 499) == 0);
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 11) == 0) din[ch] = ~din[ch];
            end
        end
        reset = 1'b0;
        cyc(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
